// File: rtl/brick_pkg.sv
// Shared types and default constants for the brick-field level loader.
package brick_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_DRAW,
        ST_LOAD,
        ST_DONE
    } state_t;

    // Default grid geometry and draw timing
    localparam int DEF_BRICK_NUM  = 128;
    localparam int DEF_COLS       = 16;
    localparam int DEF_BRICK_W    = 20;
    localparam int DEF_BRICK_H    = 10;
    localparam int DEF_DRAW_DELAY = 200;

    // Health encoding: 0 is an empty slot, all-ones is the strongest brick
    localparam int DEF_HEALTH_W   = 2;
    localparam int HEALTH_EMPTY   = 0;

    function automatic int health_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/level_loader_if.sv
// Controller <-> loader <-> drawer/RAM signal bundle.
interface level_loader_if
    import brick_pkg::*;
#(
    parameter int LEVEL_W  = 2,
    parameter int HEALTH_W = DEF_HEALTH_W,
    parameter int COORD_W  = 10,
    parameter int ADDR_W   = 10
);
    logic                start;
    logic                clear;
    logic [LEVEL_W-1:0]  level_sel;
    logic                busy;
    logic                done;
    logic                load_draw;
    logic                writeEn;
    logic [ADDR_W-1:0]   address;
    logic [COORD_W-1:0]  x_out;
    logic [COORD_W-1:0]  y_out;
    logic [HEALTH_W-1:0] health;

    // Game-controller side
    modport master (
        output start, clear, level_sel,
        input  busy, done, load_draw, writeEn, address, x_out, y_out, health
    );

    // Loader side
    modport slave (
        input  start, clear, level_sel,
        output busy, done, load_draw, writeEn, address, x_out, y_out, health
    );
endinterface

// File: rtl/level_rom.sv
// Combinational level pattern table: (level, brick index) -> health.
// Levels beyond NUM_LEVELS read as empty.
module level_rom
    import brick_pkg::*;
#(
    parameter int NUM_LEVELS = 4,
    parameter int LEVEL_W    = 2,
    parameter int ADDR_W     = 10,
    parameter int HEALTH_W   = DEF_HEALTH_W
) (
    input  logic [LEVEL_W-1:0]  level_i,
    input  logic [ADDR_W-1:0]   index_i,
    output logic [HEALTH_W-1:0] health_o
);
    localparam logic [HEALTH_W-1:0] H_MAX   = HEALTH_W'(health_max(HEALTH_W));
    localparam logic [HEALTH_W-1:0] H_EMPTY = HEALTH_W'(HEALTH_EMPTY);

    logic [HEALTH_W-1:0] low_bits;
    logic [1:0]          idx_mod4;

    assign low_bits = HEALTH_W'(index_i);
    assign idx_mod4 = 2'(index_i);

    // Pattern select: levels repeat the four base patterns if NUM_LEVELS > 4
    always_comb begin
        health_o = H_EMPTY;
        if (int'(level_i) < NUM_LEVELS) begin
            case (2'(level_i))
                2'd0:    health_o = (low_bits == H_EMPTY) ? H_MAX : low_bits; // never empty
                2'd1:    health_o = (idx_mod4 == 2'd1) ? H_EMPTY : H_MAX;     // one gap per 4
                2'd2:    health_o = low_bits;                                 // ramp
                default: health_o = (^index_i) ? H_EMPTY : H_MAX;             // parity checker
            endcase
        end
    end
endmodule

// File: rtl/level_loader.sv
// Restartable level loader: walks every brick of a level, opens a draw
// window per brick and writes its health into brick RAM.
module level_loader
    import brick_pkg::*;
#(
    parameter int BRICK_NUM  = DEF_BRICK_NUM,
    parameter int COLS       = DEF_COLS,
    parameter int BRICK_W    = DEF_BRICK_W,
    parameter int BRICK_H    = DEF_BRICK_H,
    parameter int X_OFF      = 0,
    parameter int Y_OFF      = 0,
    parameter int DRAW_DELAY = DEF_DRAW_DELAY,
    parameter int NUM_LEVELS = 4,
    parameter int LEVEL_W    = 2,
    parameter int HEALTH_W   = DEF_HEALTH_W,
    parameter int COORD_W    = 10,
    parameter int ADDR_W     = 10,
    parameter int SKIP_EMPTY = 1
) (
    input  logic          clk,
    input  logic          resetn,
    level_loader_if.slave bus
);
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DLY_W = (DRAW_DELAY > 1) ? $clog2(DRAW_DELAY) : 1;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BRICK_NUM - 1);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(COLS - 1);
    localparam logic [DLY_W-1:0]  LAST_DLY = DLY_W'(DRAW_DELAY - 1);

    state_t              state_q;
    logic                clear_q;
    logic [LEVEL_W-1:0]  level_q;
    logic [ADDR_W-1:0]   index_q;
    logic [COL_W-1:0]    col_q;
    logic [DLY_W-1:0]    dly_q;
    logic [COORD_W-1:0]  x_q;
    logic [COORD_W-1:0]  y_q;
    logic [HEALTH_W-1:0] health_q;
    logic                busy_q;
    logic                done_q;
    logic                load_draw_q;
    logic                write_en_q;

    logic                start_ok;
    logic [LEVEL_W-1:0]  sel_level;
    logic [LEVEL_W-1:0]  rom_level;
    logic [ADDR_W-1:0]   rom_index;
    logic [HEALTH_W-1:0] rom_health;
    logic                clear_d;
    logic [HEALTH_W-1:0] health_d;
    logic                draw_d;

    level_rom #(
        .NUM_LEVELS (NUM_LEVELS),
        .LEVEL_W    (LEVEL_W),
        .ADDR_W     (ADDR_W),
        .HEALTH_W   (HEALTH_W)
    ) u_rom (
        .level_i  (rom_level),
        .index_i  (rom_index),
        .health_o (rom_health)
    );

    // Look up the brick that will be current after this edge, so health and
    // the draw/skip decision are registered together with the brick index.
    always_comb begin
        start_ok  = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        sel_level = (int'(bus.level_sel) < NUM_LEVELS) ? bus.level_sel : '0;
        rom_level = start_ok ? sel_level : level_q;
        rom_index = start_ok ? '0 : (index_q + ADDR_W'(1));
        clear_d   = start_ok ? bus.clear : clear_q;
        health_d  = clear_d ? '0 : rom_health;
        draw_d    = clear_d || (SKIP_EMPTY == 0) || (rom_health != '0);
    end

    // Main FSM with counters, coordinate accumulators and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            clear_q     <= 1'b0;
            level_q     <= '0;
            index_q     <= '0;
            col_q       <= '0;
            dly_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            health_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            load_draw_q <= 1'b0;
            write_en_q  <= 1'b0;
        end else begin
            load_draw_q <= 1'b0;
            write_en_q  <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state_q     <= ST_PREP;
                        clear_q     <= bus.clear;
                        level_q     <= sel_level;
                        index_q     <= '0;
                        col_q       <= '0;
                        x_q         <= COORD_W'(X_OFF);
                        y_q         <= COORD_W'(Y_OFF);
                        health_q    <= health_d;
                        load_draw_q <= draw_d;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                    end
                end
                ST_PREP: begin
                    // load_draw is high in PREP exactly when this brick is drawn
                    if (load_draw_q) begin
                        state_q <= ST_DRAW;
                        dly_q   <= '0;
                    end else begin
                        state_q    <= ST_LOAD;
                        write_en_q <= 1'b1;
                    end
                end
                ST_DRAW: begin
                    if (dly_q == LAST_DLY) begin
                        state_q    <= ST_LOAD;
                        write_en_q <= 1'b1;
                    end else begin
                        dly_q <= dly_q + DLY_W'(1);
                    end
                end
                ST_LOAD: begin
                    if (index_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q     <= ST_PREP;
                        index_q     <= rom_index;
                        health_q    <= health_d;
                        load_draw_q <= draw_d;
                        if (col_q == LAST_COL) begin
                            col_q <= '0;
                            x_q   <= COORD_W'(X_OFF);
                            y_q   <= y_q + COORD_W'(BRICK_H);
                        end else begin
                            col_q <= col_q + COL_W'(1);
                            x_q   <= x_q + COORD_W'(BRICK_W);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.load_draw = load_draw_q;
    assign bus.writeEn   = write_en_q;
    assign bus.address   = index_q;
    assign bus.x_out     = x_q;
    assign bus.y_out     = y_q;
    assign bus.health    = health_q;
endmodule
